// File: rtl/axi4_lite_cmd_master_if.sv
// AXI4-Lite channel bundle shared by the command master and the register slave.
interface ifc_axi4_lite #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) ();
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready command in, one response out,
// plus a sticky watchdog flag that never aborts the transaction.
module axi4_lite_cmd_master #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_cmd_valid,
   output logic                        o_cmd_ready,
   input  logic                        i_cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
   input  logic [AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
   output logic                        o_rsp_valid,
   input  logic                        i_rsp_ready,
   output logic [AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
   output logic [1:0]                  o_rsp_resp,
   output logic                        o_rsp_write,
   output logic                        o_timeout,
   ifc_axi4_lite.master                if_axi
);
   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

   typedef struct packed {
      logic                      write;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [AXI_DATA_WIDTH-1:0] wdata;
      logic [STRB_W-1:0]         wstrb;
   } cmd_t;

   state_t           state;
   cmd_t             cmd_q;
   logic             awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic [CNT_W-1:0] wd_cnt;
   logic             aw_done, w_done, waiting;

   // A channel counts as done once its valid has dropped or it handshakes this cycle.
   assign aw_done = ~awvalid_q | if_axi.awready;
   assign w_done  = ~wvalid_q  | if_axi.wready;
   assign waiting = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_RESP);

   assign if_axi.awaddr  = cmd_q.addr;
   assign if_axi.awprot  = 3'b000;
   assign if_axi.awvalid = awvalid_q;
   assign if_axi.wdata   = cmd_q.wdata;
   assign if_axi.wstrb   = cmd_q.wstrb;
   assign if_axi.wvalid  = wvalid_q;
   assign if_axi.bready  = bready_q;
   assign if_axi.araddr  = cmd_q.addr;
   assign if_axi.arprot  = 3'b000;
   assign if_axi.arvalid = arvalid_q;
   assign if_axi.rready  = rready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cmd_q       <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         wd_cnt      <= '0;
         o_cmd_ready <= 1'b1;
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= '0;
         o_rsp_resp  <= 2'b00;
         o_rsp_write <= 1'b0;
         o_timeout   <= 1'b0;
      end else begin
         // Watchdog saturates at the limit; the flag is set on the edge the limit is reached.
         if (waiting && wd_cnt != CNT_MAX) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == CNT_MAX - 1'b1) o_timeout <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (i_cmd_valid && o_cmd_ready) begin
                  cmd_q.write <= i_cmd_write;
                  cmd_q.addr  <= i_cmd_addr;
                  cmd_q.wdata <= i_cmd_wdata;
                  cmd_q.wstrb <= i_cmd_wstrb;
                  o_cmd_ready <= 1'b0;
                  wd_cnt      <= '0;
                  o_timeout   <= 1'b0;
                  if (i_cmd_write) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state     <= WR_REQ;
                  end else begin
                     arvalid_q <= 1'b1;
                     state     <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (awvalid_q && if_axi.awready) awvalid_q <= 1'b0;
               if (wvalid_q && if_axi.wready)   wvalid_q  <= 1'b0;
               if (aw_done && w_done) begin
                  bready_q <= 1'b1;
                  state    <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (if_axi.bvalid) begin
                  bready_q    <= 1'b0;
                  o_rsp_rdata <= '0;
                  o_rsp_resp  <= if_axi.bresp;
                  o_rsp_write <= 1'b1;
                  o_rsp_valid <= 1'b1;
                  state       <= RSP;
               end
            end
            RD_REQ: begin
               if (if_axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (if_axi.rvalid) begin
                  rready_q    <= 1'b0;
                  o_rsp_rdata <= if_axi.rdata;
                  o_rsp_resp  <= if_axi.rresp;
                  o_rsp_write <= 1'b0;
                  o_rsp_valid <= 1'b1;
                  state       <= RSP;
               end
            end
            RSP: begin
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  o_cmd_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
